// File: rtl/eq2_pd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq2_pd_pkg
// Description : Shared types and constants for the EQ2 pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package eq2_pd_pkg;

  localparam int SYM_W     = 2;
  localparam int DEPTH_MAX = 16;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage : eq2_pd_pkg
`default_nettype wire

// File: rtl/eq2_pattern_detector_sym_eq2.sv
`default_nettype none
// ============================================================================
// Module      : sym_eq2
// Description : 2-bit symbol equality cell, one per history slot.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_eq2
  import eq2_pd_pkg::*;
(
  input  sym_t a,
  input  sym_t b,
  output logic eq
);

  // Pure combinational compare of one history slot against its pattern slot
  assign eq = (a == b);

endmodule : sym_eq2
`default_nettype wire

// File: rtl/eq2_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : eq2_pattern_detector
// Description : Streaming 2-bit-symbol pattern detector with valid/ready
//               input, registered match event output and saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module eq2_pattern_detector
  import eq2_pd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [2*DEPTH-1:0]     PATTERN,
  input  sym_t                   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       out_pos,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam int                HIST_W  = SYM_W * DEPTH;
  localparam int                FILL_W  = $clog2(DEPTH_MAX + 1);
  localparam logic [FILL_W-1:0] C_DEPTH = FILL_W'(DEPTH);

  logic [HIST_W-1:0] r_hist;
  logic [HIST_W-1:0] w_next_hist;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_next_fill;
  logic [CNT_W-1:0]  r_sym_idx;
  logic [CNT_W-1:0]  r_out_pos;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_out_valid;
  logic [DEPTH-1:0]  w_slot_eq;
  logic              w_accept;
  logic              w_full_next;
  logic              w_hit;
  logic              w_flush;
  state_t            r_state;
  state_t            w_state_nxt;

  // Ready whenever the output slot is empty or being drained this cycle
  assign in_ready    = !r_out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;

  // Would-be history and fill level including the symbol on the input
  assign w_next_hist = {r_hist[HIST_W-SYM_W-1:0], in_data};
  assign w_next_fill = (r_state == ARMED) ? C_DEPTH : r_fill + 1'b1;
  assign w_full_next = (w_next_fill == C_DEPTH);
  assign w_hit       = w_accept & w_full_next & (&w_slot_eq);
  assign w_flush     = w_hit & (OVERLAP == 0);

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      sym_eq2 u_eq (
        .a  (w_next_hist[SYM_W*k +: SYM_W]),
        .b  (PATTERN[SYM_W*k +: SYM_W]),
        .eq (w_slot_eq[k])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // Next state: arm once DEPTH symbols are held, disarm when a match flushes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_accept && w_full_next && !w_flush) w_state_nxt = ARMED;
      ARMED:   if (w_flush) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Symbol history, fill level and running symbol index
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_sym_idx <= '0;
    end else if (w_accept) begin
      r_sym_idx <= r_sym_idx + 1'b1;
      if (w_flush) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_next_hist;
        r_fill <= w_next_fill;
      end
    end
  end

  // Match event register and saturating match counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_out_pos   <= '0;
      r_match_cnt <= '0;
    end else if (w_hit) begin
      r_out_valid <= 1'b1;
      r_out_pos   <= r_sym_idx;
      if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pos   = r_out_pos;
  assign match_cnt = r_match_cnt;

endmodule : eq2_pattern_detector
`default_nettype wire

// File: tb/tb_eq2_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq2_pattern_detector
// Description : Self-checking bench; two DUTs (overlapping / flushing) share
//               stimulus and are compared against a queue-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq2_pattern_detector;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [3:0]       PATTERN;
  logic [1:0]       in_data;
  logic             in_valid;
  logic             out_ready;
  logic [1:0]       in_rdy;
  logic [1:0]       out_vld;
  logic [CNT_W-1:0] pos [2];
  logic [CNT_W-1:0] cnt [2];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  eq2_pattern_detector #(.DEPTH(DEPTH), .OVERLAP(1), .CNT_W(CNT_W)) u_ovl (
    .CLK(CLK), .RESET(RESET), .PATTERN(PATTERN), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_rdy[0]), .out_valid(out_vld[0]),
    .out_ready(out_ready), .out_pos(pos[0]), .match_cnt(cnt[0])
  );

  eq2_pattern_detector #(.DEPTH(DEPTH), .OVERLAP(0), .CNT_W(CNT_W)) u_flush (
    .CLK(CLK), .RESET(RESET), .PATTERN(PATTERN), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_rdy[1]), .out_valid(out_vld[1]),
    .out_ready(out_ready), .out_pos(pos[1]), .match_cnt(cnt[1])
  );

  // Reference model: per instance, the symbols held since the last flush
  // (newest first), a free-running index, a pending event and a count.
  logic [1:0] hs   [2][16];
  int         nh   [2];
  int         idx  [2];
  int         mcnt [2];
  int         mpos [2];
  bit         mv   [2];
  bit         started = 0;

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      bit hit;
      rdy = !mv[i] || out_ready;
      if (RESET) begin
        nh[i] = 0; idx[i] = 0; mcnt[i] = 0; mpos[i] = 0; mv[i] = 0;
        started = 1;
      end else if (in_valid && rdy) begin
        for (int k = 15; k > 0; k--) hs[i][k] = hs[i][k-1];
        hs[i][0] = in_data;
        if (nh[i] < DEPTH) nh[i] = nh[i] + 1;
        hit = (nh[i] == DEPTH);
        for (int k = 0; k < DEPTH; k++)
          if (hs[i][k] != PATTERN[2*k +: 2]) hit = 0;
        if (hit) begin
          mv[i]   = 1;
          mpos[i] = idx[i] % 16;
          if (mcnt[i] < 15) mcnt[i] = mcnt[i] + 1;
          if (i == 1) nh[i] = 0;
        end else if (mv[i] && out_ready) begin
          mv[i] = 0;
        end
        idx[i] = idx[i] + 1;
      end else if (mv[i] && out_ready) begin
        mv[i] = 0;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge CLK) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (in_rdy[i] !== (!mv[i] || out_ready)) begin
          failures++;
          $display("FAIL in_ready inst%0d t=%0t got=%0d exp=%0d", i, $time, in_rdy[i], (!mv[i] || out_ready));
        end
        checks++;
        if (out_vld[i] !== mv[i]) begin
          failures++;
          $display("FAIL out_valid inst%0d t=%0t got=%0d exp=%0d", i, $time, out_vld[i], mv[i]);
        end
        checks++;
        if (pos[i] !== CNT_W'(mpos[i])) begin
          failures++;
          $display("FAIL out_pos inst%0d t=%0t got=%0d exp=%0d", i, $time, pos[i], mpos[i]);
        end
        checks++;
        if (cnt[i] !== CNT_W'(mcnt[i])) begin
          failures++;
          $display("FAIL match_cnt inst%0d t=%0t got=%0d exp=%0d", i, $time, cnt[i], mcnt[i]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = s;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    PATTERN   = 4'b1001;
    in_data   = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
    chk("reset_valid", int'(out_vld[0]), 0);
    chk("reset_cnt",   int'(cnt[0]), 0);
    chk("reset_ready", int'(in_rdy[0]), 1);

    // Basic match then overlapping repeat
    send(2'b10); send(2'b01);
    chk("basic_valid", int'(out_vld[0]), 1);
    chk("basic_pos",   int'(pos[0]), 1);
    chk("basic_cnt",   int'(cnt[0]), 1);
    send(2'b10); send(2'b01);
    chk("second_pos",  int'(pos[0]), 3);
    chk("second_cnt",  int'(cnt[0]), 2);
    chk("flush_second_cnt", int'(cnt[1]), 2);

    // Overlap versus flush on a repeating pattern
    do_reset();
    PATTERN = 4'b0101;
    send(2'b01); send(2'b01); send(2'b01);
    chk("ovl_cnt",   int'(cnt[0]), 2);
    chk("ovl_pos",   int'(pos[0]), 2);
    chk("flush_cnt", int'(cnt[1]), 1);
    chk("flush_pos", int'(pos[1]), 1);

    // Backpressure holds the event and blocks input
    do_reset();
    PATTERN   = 4'b1001;
    out_ready = 1'b0;
    send(2'b10); send(2'b01);
    in_valid = 1'b1;
    in_data  = 2'b01;
    cyc(); cyc(); cyc();
    chk("bp_ready", int'(in_rdy[0]), 0);
    chk("bp_pos",   int'(pos[0]), 1);
    chk("bp_valid", int'(out_vld[0]), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_rdy[0]), 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_popped", int'(out_vld[0]), 0);
    chk("bp_cnt",    int'(cnt[0]), 1);

    // Pop and new hit in the same cycle
    do_reset();
    PATTERN   = 4'b0101;
    out_ready = 1'b0;
    send(2'b01); send(2'b01);
    out_ready = 1'b1;
    send(2'b01);
    chk("coll_valid", int'(out_vld[0]), 1);
    chk("coll_pos",   int'(pos[0]), 2);
    chk("coll_cnt",   int'(cnt[0]), 2);
    chk("coll_flush_valid", int'(out_vld[1]), 0);

    // Counter saturation and index wrap
    do_reset();
    for (int n = 0; n < 21; n++) begin
      send(2'b01);
      if (n == 16) chk("wrap_pos", int'(pos[0]), 0);
    end
    chk("sat_cnt",       int'(cnt[0]), 15);
    chk("sat_flush_cnt", int'(cnt[1]), 10);

    // Reset with an event pending, then fresh fill required
    out_ready = 1'b0;
    do_reset();
    chk("rst_valid", int'(out_vld[0]), 0);
    chk("rst_pos",   int'(pos[0]), 0);
    chk("rst_cnt",   int'(cnt[0]), 0);
    out_ready = 1'b1;
    send(2'b01);
    chk("rst_one_sym", int'(out_vld[0]), 0);
    send(2'b01);
    chk("rst_two_sym", int'(out_vld[0]), 1);
    chk("rst_two_pos", int'(pos[0]), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) PATTERN = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                              : 2'($urandom_range(1, 2));
      out_ready = ($urandom_range(0, 2) != 0);
      RESET     = ($urandom_range(0, 299) == 0);
      cyc();
    end
    RESET    = 1'b0;
    in_valid = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_eq2_pattern_detector
`default_nettype wire
